mem_responder: RTL

- Memory-side responder for the pipeline core's instruction and data ports.
- Answers `I_ADDR`/`im_oen` fetches with `IR`.
- Answers `D_ADDR`/`D_OUT`/`dm_oen`/`dm_wen` accesses with `D_IN`.
- Contains a byte-serial program loader FSM that fills the shared word array while holding the core in reset, then releases it.

---
 rtl/mem_responder_if.sv | 49 ++++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: bundles the core-facing instruction/data ports and the
// byte-serial loader port of mem_responder.
//   I_ADDR/im_oen/IR              instruction fetch (enable active-low)
//   D_ADDR/D_OUT/dm_oen/dm_wen/D_IN data access (enables active-low)
//   ld_valid/ld_data/ld_last/ld_ready  loader byte stream
//   ld_done/cpu_rst_n             load status and core reset release
//   par_err                       parity error flag (MEM_PARITY_EN only)
// Modports: master = core/loader side, slave = responder side.
// Optional feature macro: MEM_PARITY_EN.
interface mem_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] I_ADDR;
    logic              im_oen;
    logic [DATA_W-1:0] IR;
    logic [ADDR_W-1:0] D_ADDR;
    logic [DATA_W-1:0] D_OUT;
    logic              dm_oen;
    logic              dm_wen;
    logic [DATA_W-1:0] D_IN;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              cpu_rst_n;
`ifdef MEM_PARITY_EN
    logic              par_err;
`endif

    modport master (
        output I_ADDR, im_oen, D_ADDR, D_OUT, dm_oen, dm_wen,
        output ld_valid, ld_data, ld_last,
`ifdef MEM_PARITY_EN
        input  par_err,
`endif
        input  IR, D_IN, ld_ready, ld_done, cpu_rst_n
    );

    modport slave (
        input  I_ADDR, im_oen, D_ADDR, D_OUT, dm_oen, dm_wen,
        input  ld_valid, ld_data, ld_last,
`ifdef MEM_PARITY_EN
        output par_err,
`endif
        output IR, D_IN, ld_ready, ld_done, cpu_rst_n
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the pipeline core.
// A byte-serial loader fills the shared word array (little-endian, 4 bytes
// per word) while the core is held in reset; a 4th byte flagged ld_last
// finishes the load and releases the core. In RUN the instruction port and
// the data port read with 1-cycle registered latency; data writes are
// write-through on the data port and write-first toward instruction fetch.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous reset, active-high (memory contents are kept)
//   bus   mem_responder_if.slave (core ports, loader ports, status)
// Optional feature macro: MEM_PARITY_EN adds a per-word even-parity bit and
// the registered par_err output.
module mem_responder #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t            state, state_nxt;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;      // bytes 0..2 of the word being assembled
    logic [ADDR_W-1:0] ptr;

    logic              ld_ready, ld_done, cpu_rst_n;
    logic              ld_acc, ld_wr;
    logic [DATA_W-1:0] ld_word;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_PARITY_EN
    logic              par_mem [DEPTH];
    logic              par_err;
    logic              i_perr, d_perr;
`endif

    logic              i_rng, d_rng;
    logic              run, core_wr, i_wf;
    logic [DATA_W-1:0] i_rd, d_rd;

    // Address range check collapses to a constant when the array covers the
    // whole address space.
    generate
        if (DEPTH >= (1 << ADDR_W)) begin : g_full
            assign i_rng = 1'b1;
            assign d_rng = 1'b1;
        end else begin : g_part
            assign i_rng = 32'(bus.I_ADDR) < DEPTH;
            assign d_rng = 32'(bus.D_ADDR) < DEPTH;
        end
    endgenerate

    // ---------------- loader FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        cpu_rst_n = 1'b0;
        ld_acc    = 1'b0;
        ld_wr     = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = ~rst;
                ld_acc   = bus.ld_valid & ld_ready;
                ld_wr    = ld_acc && (byte_cnt == 2'd3);
                // ld_last only counts on a word boundary
                if (ld_wr && bus.ld_last) state_nxt = RUN;
            end
            RUN: begin
                ld_done   = 1'b1;
                cpu_rst_n = 1'b1;
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign ld_word = {bus.ld_data, asm_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            asm_q    <= '0;
            ptr      <= '0;
        end else if (ld_acc) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    asm_q[7:0]   <= bus.ld_data;
                2'd1:    asm_q[15:8]  <= bus.ld_data;
                2'd2:    asm_q[23:16] <= bus.ld_data;
                default: ptr <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
            endcase
        end
    end

    assign bus.ld_ready  = ld_ready;
    assign bus.ld_done   = ld_done;
    assign bus.cpu_rst_n = cpu_rst_n;

    // ---------------- memory array ----------------
    assign run     = (state == RUN) && !rst;
    assign core_wr = run && !bus.dm_wen && d_rng;
    // fetch hits the word being written this cycle
    assign i_wf    = core_wr && (bus.D_ADDR == bus.I_ADDR);

    // No reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (ld_wr) begin
            mem[ptr] <= ld_word;
`ifdef MEM_PARITY_EN
            par_mem[ptr] <= ^ld_word;
`endif
        end else if (core_wr) begin
            mem[bus.D_ADDR] <= bus.D_OUT;
`ifdef MEM_PARITY_EN
            par_mem[bus.D_ADDR] <= ^bus.D_OUT;
`endif
        end
    end

    assign i_rd = i_rng ? mem[bus.I_ADDR] : '0;
    assign d_rd = d_rng ? mem[bus.D_ADDR] : '0;
`ifdef MEM_PARITY_EN
    assign i_perr = i_rng && ((^mem[bus.I_ADDR]) != par_mem[bus.I_ADDR]);
    assign d_perr = d_rng && ((^mem[bus.D_ADDR]) != par_mem[bus.D_ADDR]);
`endif

    // ---------------- read ports ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.IR   <= '0;
            bus.D_IN <= '0;
`ifdef MEM_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
`ifdef MEM_PARITY_EN
            // bypassed write data is freshly computed, so never flagged
            par_err <= run && ((!bus.im_oen && !i_wf && i_perr) ||
                               (!bus.dm_oen && !core_wr && d_perr));
`endif
            if (run) begin
                if (!bus.im_oen) bus.IR   <= i_wf ? bus.D_OUT : i_rd;
                if (!bus.dm_oen) bus.D_IN <= core_wr ? bus.D_OUT : d_rd;
            end
        end
    end

`ifdef MEM_PARITY_EN
    assign bus.par_err = par_err;
`endif

endmodule
